// File: rtl/bbox_pixel_walker.sv
`default_nettype none
// bbox_pixel_walker: walks every pixel of a clamped integer bounding box, one (x,y) per cycle.
// Optional boustrophedon order when BBOX_WALK_SERPENTINE_EN is defined (default: plain raster).
module bbox_pixel_walker #(
  parameter int COORD_W = 16,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int PIX_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bbox_valid,
  output logic               bbox_ready,
  input  logic [COORD_W-1:0] bbox_x_min_int,
  input  logic [COORD_W-1:0] bbox_x_max_int,
  input  logic [COORD_W-1:0] bbox_y_min_int,
  input  logic [COORD_W-1:0] bbox_y_max_int,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_x,
  output logic [PIX_W-1:0]   pix_y,
  output logic               pix_last,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMG_H - 1);

  function automatic logic [PIX_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                             input logic [COORD_W-1:0] lim);
    clamp = (v > lim) ? lim[PIX_W-1:0] : v[PIX_W-1:0];
  endfunction

  state_t           state_q;
  logic             bbox_ready_q;
  logic             pix_valid_q;
  logic             done_q;
  logic [PIX_W-1:0] pix_x_q, pix_y_q;
  logic [PIX_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;

  logic [PIX_W-1:0] x_min_d, x_max_d, y_min_d, y_max_d;
  logic             empty_d;
  logic             row_end;
  logic [PIX_W-1:0] pix_x_d, pix_y_d;
  logic             last_w;

  assign x_min_d = clamp(bbox_x_min_int, X_LIM);
  assign x_max_d = clamp(bbox_x_max_int, X_LIM);
  assign y_min_d = clamp(bbox_y_min_int, Y_LIM);
  assign y_max_d = clamp(bbox_y_max_int, Y_LIM);
  assign empty_d = (x_min_d > x_max_d) || (y_min_d > y_max_d);

`ifdef BBOX_WALK_SERPENTINE_EN
  logic dir_q;  // 0: walking toward x_max, 1: walking toward x_min

  assign row_end = dir_q ? (pix_x_q == x_min_q) : (pix_x_q == x_max_q);
  // Row step keeps the column; the direction register flips instead.
  assign pix_x_d = row_end ? pix_x_q
                 : (dir_q ? pix_x_q - PIX_W'(1) : pix_x_q + PIX_W'(1));
`else
  assign row_end = (pix_x_q == x_max_q);
  assign pix_x_d = row_end ? x_min_q : pix_x_q + PIX_W'(1);
`endif
  assign pix_y_d = row_end ? pix_y_q + PIX_W'(1) : pix_y_q;

  // Termination is decided by the bound compare, so counters never need to wrap.
  assign last_w = pix_valid_q && row_end && (pix_y_q == y_max_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bbox_ready_q <= 1'b1;
      pix_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
`ifdef BBOX_WALK_SERPENTINE_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bbox_valid && bbox_ready_q) begin
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_min_q      <= y_min_d;
            y_max_q      <= y_max_d;
            pix_x_q      <= x_min_d;
            pix_y_q      <= y_min_d;
            bbox_ready_q <= 1'b0;
`ifdef BBOX_WALK_SERPENTINE_EN
            dir_q        <= 1'b0;
`endif
            if (empty_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= SCAN;
              pix_valid_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (pix_ready) begin
            if (last_w) begin
              state_q     <= DONE;
              pix_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              pix_x_q <= pix_x_d;
              pix_y_q <= pix_y_d;
`ifdef BBOX_WALK_SERPENTINE_EN
              if (row_end) dir_q <= ~dir_q;
`endif
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_q       <= 1'b0;
          bbox_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          pix_valid_q  <= 1'b0;
          done_q       <= 1'b0;
          bbox_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bbox_ready = bbox_ready_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_last   = last_w;
  assign done       = done_q;

endmodule
`default_nettype wire
